// File: rtl/i2c_slave_pkg.sv
// Shared types and constants for the I2C slave protocol engine.
package i2c_slave_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WR_DATA,
    ST_WR_ACK,
    ST_RD_DATA,
    ST_RD_ACK,
    ST_WAIT_STOP
  } t_i2c_slv_state;

  localparam logic       C_I2C_ACK       = 1'b0;
  localparam logic       C_I2C_NACK      = 1'b1;
  localparam logic [7:0] C_TX_EMPTY_BYTE = 8'hFF;

endpackage

// File: rtl/i2c_slave_fifo.sv
// Byte FIFO with show-ahead read, occupancy level and full/empty flags.
module i2c_slave_fifo #(
  parameter int G_DEPTH = 256,
  parameter int P       = $clog2(G_DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en_i,
  input  logic [7:0]   wr_data_i,
  input  logic         rd_en_i,
  output logic [7:0]   rd_data_o,
  output logic         full_o,
  output logic         empty_o,
  output logic [P:0]   level_o
);

  localparam logic [P:0] C_FULL_LEVEL = (P+1)'(G_DEPTH);

  logic [7:0]   mem_q [G_DEPTH];
  logic [P-1:0] wr_ptr_q;
  logic [P-1:0] rd_ptr_q;
  logic [P:0]   level_q;
  logic         do_wr;
  logic         do_rd;

  assign full_o    = (level_q == C_FULL_LEVEL);
  assign empty_o   = (level_q == '0);
  assign level_o   = level_q;
  assign rd_data_o = mem_q[rd_ptr_q];
  assign do_wr     = wr_en_i & ~full_o;
  assign do_rd     = rd_en_i & ~empty_o;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({do_wr, do_rd})
        2'b10:   level_q <= level_q + (P+1)'(1);
        2'b01:   level_q <= level_q - (P+1)'(1);
        default: ;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; pointers and level define validity, and a
  // reset-free array maps onto RAM instead of thousands of resettable flops.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/i2c_slave_ctrl.sv
// I2C slave protocol engine: bus synchronizer, START/STOP decode, byte shifter and FSM
// sequencing a TX FIFO (read data) and an RX FIFO (write data).
module i2c_slave_ctrl
  import i2c_slave_pkg::*;
#(
  parameter int  G_SLAVE_I2C_FIFO_WIDTH = 256,
  parameter int  G_SYNC_STAGES          = 2,
  localparam int P                      = $clog2(G_SLAVE_I2C_FIFO_WIDTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [6:0]   i2c_slave_addr,
  input  logic         scl_i,
  input  logic         sda_i,
  output logic         sda_oe,
  input  logic         tx_wr_en,
  input  logic [7:0]   tx_wr_data,
  output logic         tx_full,
  input  logic         rx_rd_en,
  output logic [7:0]   rx_rd_data,
  output logic         rx_empty,
  output logic [P:0]   tx_level,
  output logic [P:0]   rx_level,
  output logic         busy,
  output logic         addr_match,
  output logic         stop_det,
  output logic         rx_overflow,
  output logic         tx_underrun
);

  logic [G_SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic                     scl_prev_q, sda_prev_q;
  logic                     scl_s, sda_s, scl_rise, scl_fall, bus_start, bus_stop;

  t_i2c_slv_state state_q, state_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]     shift_q, shift_d;
  logic           sda_oe_q, sda_oe_d;
  logic           rw_q, rw_d;
  logic           nack_q, nack_d;
  logic           addr_match_q, addr_match_d, stop_det_q, stop_det_d;
  logic           rx_overflow_q, rx_overflow_d, tx_underrun_q, tx_underrun_d;

  logic           tx_empty, tx_pop, rx_full, rx_push, load_tx;
  logic [7:0]     tx_rd_data, tx_head, rx_byte;

  // Sync flops idle high so a reset never fabricates a START/STOP on an idle bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[G_SYNC_STAGES-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[G_SYNC_STAGES-2:0], sda_i};
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
    end
  end

  assign scl_s     = scl_sync_q[G_SYNC_STAGES-1];
  assign sda_s     = sda_sync_q[G_SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s & scl_prev_q;
  assign bus_start = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign bus_stop  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

  assign tx_head = tx_empty ? C_TX_EMPTY_BYTE : tx_rd_data;
  assign rx_byte = {shift_q[6:0], sda_s};
  assign tx_pop  = load_tx & ~tx_empty;

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    sda_oe_d      = sda_oe_q;
    rw_d          = rw_q;
    nack_d        = nack_q;
    addr_match_d  = 1'b0;
    stop_det_d    = 1'b0;
    rx_overflow_d = 1'b0;
    tx_underrun_d = 1'b0;
    rx_push       = 1'b0;
    load_tx       = 1'b0;
    if (bus_stop) begin
      state_d    = ST_IDLE;
      sda_oe_d   = 1'b0;
      stop_det_d = 1'b1;
    end else if (bus_start) begin
      state_d   = ST_ADDR;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: ;
        ST_ADDR: if (scl_rise) begin
          shift_d   = rx_byte;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            bit_cnt_d = '0;
            if (shift_q[6:0] == i2c_slave_addr) begin
              state_d      = ST_ADDR_ACK;
              rw_d         = sda_s;
              addr_match_d = 1'b1;
            end else begin
              state_d = ST_WAIT_STOP;
            end
          end
        end
        // ACK phases use bit_cnt as a flag: first fall drives the ACK, second ends it.
        ST_ADDR_ACK: if (scl_fall) begin
          if (bit_cnt_q == '0) begin
            sda_oe_d  = 1'b1;
            bit_cnt_d = 3'd1;
          end else begin
            bit_cnt_d = '0;
            if (rw_q) begin
              state_d = ST_RD_DATA;
              load_tx = 1'b1;
            end else begin
              state_d  = ST_WR_DATA;
              sda_oe_d = 1'b0;
            end
          end
        end
        ST_WR_DATA: if (scl_rise) begin
          shift_d   = rx_byte;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d       = ST_WR_ACK;
            bit_cnt_d     = '0;
            nack_d        = rx_full;
            rx_overflow_d = rx_full;
            rx_push       = ~rx_full;
          end
        end
        ST_WR_ACK: if (scl_fall) begin
          if (bit_cnt_q == '0) begin
            sda_oe_d  = ~nack_q;
            bit_cnt_d = 3'd1;
          end else begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = '0;
            state_d   = ST_WR_DATA;
          end
        end
        ST_RD_DATA: if (scl_fall) begin
          if (bit_cnt_q == 3'd7) begin
            sda_oe_d = 1'b0;
            state_d  = ST_RD_ACK;
          end else begin
            shift_d   = {shift_q[6:0], 1'b0};
            sda_oe_d  = ~shift_q[6];
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
        ST_RD_ACK: begin
          if (scl_rise && sda_s == C_I2C_NACK) begin
            state_d = ST_WAIT_STOP;
          end else if (scl_fall) begin
            state_d   = ST_RD_DATA;
            bit_cnt_d = '0;
            load_tx   = 1'b1;
          end
        end
        ST_WAIT_STOP: sda_oe_d = 1'b0;
        default: state_d = ST_IDLE;
      endcase
    end
    if (load_tx) begin
      shift_d       = tx_head;
      sda_oe_d      = ~tx_head[7];
      tx_underrun_d = tx_empty;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      sda_oe_q      <= 1'b0;
      rw_q          <= 1'b0;
      nack_q        <= 1'b0;
      addr_match_q  <= 1'b0;
      stop_det_q    <= 1'b0;
      rx_overflow_q <= 1'b0;
      tx_underrun_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      sda_oe_q      <= sda_oe_d;
      rw_q          <= rw_d;
      nack_q        <= nack_d;
      addr_match_q  <= addr_match_d;
      stop_det_q    <= stop_det_d;
      rx_overflow_q <= rx_overflow_d;
      tx_underrun_q <= tx_underrun_d;
    end
  end

  assign sda_oe      = sda_oe_q;
  assign addr_match  = addr_match_q;
  assign stop_det    = stop_det_q;
  assign rx_overflow = rx_overflow_q;
  assign tx_underrun = tx_underrun_q;
  assign busy        = state_q inside {ST_ADDR_ACK, ST_WR_DATA, ST_WR_ACK, ST_RD_DATA, ST_RD_ACK};

  i2c_slave_fifo #(.G_DEPTH(G_SLAVE_I2C_FIFO_WIDTH), .P(P)) u_tx_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (tx_wr_en),
    .wr_data_i (tx_wr_data),
    .rd_en_i   (tx_pop),
    .rd_data_o (tx_rd_data),
    .full_o    (tx_full),
    .empty_o   (tx_empty),
    .level_o   (tx_level)
  );

  i2c_slave_fifo #(.G_DEPTH(G_SLAVE_I2C_FIFO_WIDTH), .P(P)) u_rx_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (rx_push),
    .wr_data_i (rx_byte),
    .rd_en_i   (rx_rd_en),
    .rd_data_o (rx_rd_data),
    .full_o    (rx_full),
    .empty_o   (rx_empty),
    .level_o   (rx_level)
  );

endmodule

// File: tb/tb_i2c_slave_ctrl.sv
// Directed bench for i2c_slave_ctrl: a bit-banged I2C master drives the bus, the host side
// pushes TX and pops RX, and pulse outputs are counted by monitors.
module tb_i2c_slave_ctrl;
  import i2c_slave_pkg::*;

  localparam int G = 4;
  localparam int P = 2;
  localparam int Q = 10;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [6:0]   own_addr = 7'h2A;
  logic         scl_m = 1'b1;
  logic         sda_m = 1'b1;
  logic         sda_bus;
  logic         sda_oe;
  logic         tx_wr_en = 1'b0;
  logic [7:0]   tx_wr_data = '0;
  logic         tx_full;
  logic         rx_rd_en = 1'b0;
  logic [7:0]   rx_rd_data;
  logic         rx_empty;
  logic [P:0]   tx_level, rx_level;
  logic         busy, addr_match, stop_det, rx_overflow, tx_underrun;

  int checks = 0;
  int failures = 0;
  int n_match = 0, n_stop = 0, n_ovf = 0, n_undr = 0, n_oe = 0;

  assign sda_bus = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  i2c_slave_ctrl #(.G_SLAVE_I2C_FIFO_WIDTH(G), .G_SYNC_STAGES(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .i2c_slave_addr (own_addr),
    .scl_i          (scl_m),
    .sda_i          (sda_bus),
    .sda_oe         (sda_oe),
    .tx_wr_en       (tx_wr_en),
    .tx_wr_data     (tx_wr_data),
    .tx_full        (tx_full),
    .rx_rd_en       (rx_rd_en),
    .rx_rd_data     (rx_rd_data),
    .rx_empty       (rx_empty),
    .tx_level       (tx_level),
    .rx_level       (rx_level),
    .busy           (busy),
    .addr_match     (addr_match),
    .stop_det       (stop_det),
    .rx_overflow    (rx_overflow),
    .tx_underrun    (tx_underrun)
  );

  always @(posedge clk) begin
    if (addr_match)  n_match <= n_match + 1;
    if (stop_det)    n_stop  <= n_stop + 1;
    if (rx_overflow) n_ovf   <= n_ovf + 1;
    if (tx_underrun) n_undr  <= n_undr + 1;
    if (sda_oe)      n_oe    <= n_oe + 1;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic bit_wr(input logic b);
    sda_m = b;  wait_q();
    scl_m = 1'b1; wait_q(); wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic bit_rd(output logic b);
    sda_m = 1'b1; wait_q();
    scl_m = 1'b1; wait_q();
    b = sda_bus;  wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic start_c();
    sda_m = 1'b1; wait_q();
    scl_m = 1'b1; wait_q();
    sda_m = 1'b0; wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic stop_c();
    sda_m = 1'b0; wait_q();
    scl_m = 1'b1; wait_q();
    sda_m = 1'b1; wait_q(); wait_q();
  endtask

  task automatic byte_wr(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) bit_wr(d[i]);
    bit_rd(ack);
  endtask

  task automatic byte_rd(output logic [7:0] d, input logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      bit_rd(b);
      d[i] = b;
    end
    bit_wr(ack);
  endtask

  task automatic push_tx(input logic [7:0] d);
    @(negedge clk);
    tx_wr_en = 1'b1; tx_wr_data = d;
    @(negedge clk);
    tx_wr_en = 1'b0;
  endtask

  task automatic pop_rx(input string tag, input logic [7:0] exp);
    @(negedge clk);
    check(tag, rx_rd_data, exp);
    rx_rd_en = 1'b1;
    @(negedge clk);
    rx_rd_en = 1'b0;
  endtask

  initial begin
    logic       ack;
    logic [7:0] d;
    int         m0, s0, o0, u0, e0;

    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_sda_oe", sda_oe, 0);
    check("rst_tx_full", tx_full, 0);
    check("rst_rx_empty", rx_empty, 1);
    check("rst_levels", {tx_level, rx_level}, 0);
    check("rst_pulses", {busy, addr_match, stop_det, rx_overflow, tx_underrun}, 0);

    // 1: master write 11,22,33 to own address
    m0 = n_match; s0 = n_stop;
    start_c();
    byte_wr(8'h54, ack); check("t1_addr_ack", ack, C_I2C_ACK);
    check("t1_match", n_match - m0, 1);
    check("t1_busy", busy, 1);
    byte_wr(8'h11, ack); check("t1_ack1", ack, C_I2C_ACK);
    byte_wr(8'h22, ack); check("t1_ack2", ack, C_I2C_ACK);
    byte_wr(8'h33, ack); check("t1_ack3", ack, C_I2C_ACK);
    stop_c();
    check("t1_stop", n_stop - s0, 1);
    check("t1_rx_level", rx_level, 3);
    check("t1_idle", busy, 0);
    pop_rx("t1_pop1", 8'h11);
    pop_rx("t1_pop2", 8'h22);
    pop_rx("t1_pop3", 8'h33);
    check("t1_rx_empty", rx_empty, 1);

    // 2: master read A5,5A, ACK then NACK
    push_tx(8'hA5); push_tx(8'h5A);
    check("t2_tx_level", tx_level, 2);
    start_c();
    byte_wr(8'h55, ack); check("t2_addr_ack", ack, C_I2C_ACK);
    byte_rd(d, C_I2C_ACK);  check("t2_rd1", d, 8'hA5);
    byte_rd(d, C_I2C_NACK); check("t2_rd2", d, 8'h5A);
    check("t2_tx_level0", tx_level, 0);
    check("t2_wait_stop", dut.state_q, 32'(ST_WAIT_STOP));
    check("t2_busy", busy, 0);
    stop_c();
    check("t2_idle", dut.state_q, 32'(ST_IDLE));

    // 3: write to a foreign address
    m0 = n_match; e0 = n_oe;
    start_c();
    byte_wr(8'h56, ack); check("t3_addr_nack", ack, C_I2C_NACK);
    byte_wr(8'h77, ack); check("t3_data_nack", ack, C_I2C_NACK);
    stop_c();
    check("t3_no_match", n_match - m0, 0);
    check("t3_no_drive", n_oe - e0, 0);
    check("t3_rx_level", rx_level, 0);

    // 4: fill RX to G, then one more byte overflows
    o0 = n_ovf;
    start_c();
    byte_wr(8'h54, ack); check("t4_addr_ack", ack, C_I2C_ACK);
    for (int i = 0; i < G; i++) begin
      byte_wr(8'h40 + 8'(i), ack);
      check("t4_fill_ack", ack, C_I2C_ACK);
    end
    byte_wr(8'h99, ack); check("t4_ovf_nack", ack, C_I2C_NACK);
    check("t4_ovf_pulse", n_ovf - o0, 1);
    stop_c();
    check("t4_rx_level", rx_level, G);
    for (int i = 0; i < G; i++) pop_rx("t4_pop", 8'h40 + 8'(i));

    // 5: read with TX empty, then G+2 writes over two transactions
    u0 = n_undr;
    start_c();
    byte_wr(8'h55, ack); check("t5_addr_ack", ack, C_I2C_ACK);
    byte_rd(d, C_I2C_NACK); check("t5_underrun_byte", d, C_TX_EMPTY_BYTE);
    stop_c();
    check("t5_underrun", n_undr - u0, 1);
    check("t5_tx_level", tx_level, 0);
    for (int t = 0; t < 2; t++) begin
      start_c();
      byte_wr(8'h54, ack); check("t5_wr_addr_ack", ack, C_I2C_ACK);
      for (int i = 0; i < 3; i++) begin
        byte_wr(8'hB0 + 8'(3 * t + i), ack);
        check("t5_wr_ack", ack, C_I2C_ACK);
      end
      stop_c();
      check("t5_rx_level", rx_level, 3);
      for (int i = 0; i < 3; i++) pop_rx("t5_wrap_pop", 8'hB0 + 8'(3 * t + i));
    end

    // 6: repeated START write -> read, then reset mid-byte
    push_tx(8'h3C);
    start_c();
    byte_wr(8'h54, ack); check("t6_waddr_ack", ack, C_I2C_ACK);
    byte_wr(8'hC1, ack); check("t6_wdata_ack", ack, C_I2C_ACK);
    start_c();
    byte_wr(8'h55, ack); check("t6_raddr_ack", ack, C_I2C_ACK);
    byte_rd(d, C_I2C_NACK); check("t6_rd", d, 8'h3C);
    stop_c();
    check("t6_rx_level", rx_level, 1);

    push_tx(8'h00); push_tx(8'h00);
    start_c();
    byte_wr(8'h55, ack); check("t6_rst_addr_ack", ack, C_I2C_ACK);
    for (int i = 0; i < 3; i++) bit_rd(ack);
    check("t6_pre_rst_oe", sda_oe, 1);
    check("t6_pre_rst_tx", tx_level, 1);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("t6_rst_oe", sda_oe, 0);
    check("t6_rst_levels", {tx_level, rx_level}, 0);
    check("t6_rst_busy", busy, 0);
    sda_m = 1'b1; wait_q();
    scl_m = 1'b1; wait_q(); wait_q();
    start_c();
    byte_wr(8'h54, ack); check("t6_post_addr_ack", ack, C_I2C_ACK);
    byte_wr(8'h5E, ack); check("t6_post_data_ack", ack, C_I2C_ACK);
    stop_c();
    check("t6_post_level", rx_level, 1);
    pop_rx("t6_post_pop", 8'h5E);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
